// File: rtl/inv_selftest_if.sv
// Control/status and probe signals shared between the inverter self-test
// checker and its host. The checker side uses the master modport.
interface inv_selftest_if #(
  parameter int ERR_W = 8,
  parameter int IDX_W = 5
);
  logic             start;
  logic             dut_a;
  logic             dut_y;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] vec_idx;

  modport master (
    input  start,
    input  dut_y,
    output dut_a,
    output busy,
    output done,
    output pass,
    output err_count,
    output vec_idx
  );

  modport slave (
    output start,
    output dut_y,
    input  dut_a,
    input  busy,
    input  done,
    input  pass,
    input  err_count,
    input  vec_idx
  );
endinterface

// File: rtl/inv_selftest.sv
// On-chip self-test for a single-bit inverter: applies an alternating 0/1
// stimulus, samples Y after a settle time, and counts mismatches against ~A.
module inv_selftest #(
  parameter int NUM_VECTORS   = 16,
  parameter int SETTLE_CYCLES = 2,
  parameter int ERR_W         = 8,
  parameter int IDX_W         = 5
) (
  input logic           clk,
  input logic           rst_n,
  inv_selftest_if.master bus
);
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]       state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [IDX_W-1:0] idx_r, idx_s, idx_inc_s;
  logic [ERR_W-1:0] err_r, err_s;
  logic             a_r, a_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;

  // The counter sticks at all-ones so a long failing run never reads as clean.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + ERR_W'(1);
    end
  endfunction

  assign idx_inc_s = idx_r + IDX_W'(1);

  // Next-state and next-output computation for the run sequencer.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    idx_s   = idx_r;
    err_s   = err_r;
    a_s     = a_r;
    busy_s  = busy_r;
    done_s  = done_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          state_s = ST_SETTLE;
          cnt_s   = {CNT_W{1'b0}};
          idx_s   = {IDX_W{1'b0}};
          err_s   = {ERR_W{1'b0}};
          a_s     = 1'b0;
          busy_s  = 1'b1;
          done_s  = 1'b0;
        end else begin
          state_s = state_r;
        end
      end
      ST_SETTLE: begin
        if (cnt_r == CNT_W'(SETTLE_CYCLES - 1)) begin
          state_s = ST_CHECK;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (bus.dut_y != ~a_r) begin
          err_s = sat_inc(err_r);
        end else begin
          err_s = err_r;
        end
        if (idx_r == IDX_W'(NUM_VECTORS - 1)) begin
          state_s = ST_DONE;
          a_s     = 1'b0;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end else begin
          state_s = ST_SETTLE;
          idx_s   = idx_inc_s;
          a_s     = idx_inc_s[0];
          cnt_s   = {CNT_W{1'b0}};
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = {CNT_W{1'b0}};
        idx_s   = {IDX_W{1'b0}};
        err_s   = {ERR_W{1'b0}};
        a_s     = 1'b0;
        busy_s  = 1'b0;
        done_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= {CNT_W{1'b0}};
      idx_r   <= {IDX_W{1'b0}};
      err_r   <= {ERR_W{1'b0}};
      a_r     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      idx_r   <= idx_s;
      err_r   <= err_s;
      a_r     <= a_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign bus.dut_a     = a_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err_count = err_r;
  assign bus.vec_idx   = idx_r;
  assign bus.pass      = done_r & (err_r == {ERR_W{1'b0}});
endmodule
